// File: rtl/loop_fetch_seq.sv
// Instruction-fetch sequencer: prologue, loop body repeated iter_total times, epilogue.
// Optional stall performance counter enabled by LOOP_FETCH_PERF_EN.
module loop_fetch_seq #(
  parameter int unsigned PRO_LEN  = 4,
  parameter int unsigned BODY_LEN = 18,
  parameter int unsigned EPI_LEN  = 2,
  parameter int unsigned CNT_W    = 19,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  iter_total,
  input  logic              advance,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  iter_cnt,
  output logic              in_body,
  output logic [31:0]       stall_cnt
);

  localparam int unsigned WW = ADDR_W - 2;
  localparam logic [WW-1:0] W_PRO_LAST   = WW'(PRO_LEN - 1);
  localparam logic [WW-1:0] W_BODY_FIRST = WW'(PRO_LEN);
  localparam logic [WW-1:0] W_BODY_LAST  = WW'(PRO_LEN + BODY_LEN - 1);
  localparam logic [WW-1:0] W_EPI_FIRST  = WW'(PRO_LEN + BODY_LEN);
  localparam logic [WW-1:0] W_EPI_LAST   = WW'(PRO_LEN + BODY_LEN + EPI_LEN - 1);
  localparam bit            HAS_EPI      = (EPI_LEN != 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRO  = 3'd1,
    S_BODY = 3'd2,
    S_EPI  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WW-1:0]    w, w_nxt;
  logic [CNT_W-1:0] cnt_nxt, limit, limit_nxt, cnt_inc_c;
  logic             start_ok_c;
  logic             busy_nxt, done_nxt, in_body_nxt;

  assign start_ok_c = start && ((state == S_IDLE) || (state == S_DONE));
  // iter_cnt < limit whenever BODY is active, so the increment cannot wrap
  assign cnt_inc_c  = iter_cnt + CNT_W'(1);

  // State register together with the word index, counters and registered flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      w        <= '0;
      iter_cnt <= '0;
      limit    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_body  <= 1'b0;
    end else begin
      state    <= state_nxt;
      w        <= w_nxt;
      iter_cnt <= cnt_nxt;
      limit    <= limit_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      in_body  <= in_body_nxt;
    end
  end

  // Next-state and word-index sequencing
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    cnt_nxt   = iter_cnt;
    limit_nxt = limit;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok_c) begin
          limit_nxt = iter_total;
          w_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = S_PRO;
        end
      end
      S_PRO: begin
        if (advance) begin
          if (w < W_PRO_LAST) begin
            w_nxt = w + WW'(1);
          end else if (limit == '0) begin
            if (HAS_EPI) begin
              state_nxt = S_EPI;
              w_nxt     = W_EPI_FIRST;
            end else begin
              state_nxt = S_DONE;
            end
          end else begin
            state_nxt = S_BODY;
            w_nxt     = W_BODY_FIRST;
          end
        end
      end
      S_BODY: begin
        if (advance) begin
          if (w < W_BODY_LAST) begin
            w_nxt = w + WW'(1);
          end else begin
            cnt_nxt = cnt_inc_c;
            if (cnt_inc_c == limit) begin
              if (HAS_EPI) begin
                state_nxt = S_EPI;
                w_nxt     = W_EPI_FIRST;
              end else begin
                state_nxt = S_DONE;
              end
            end else begin
              w_nxt = W_BODY_FIRST;
            end
          end
        end
      end
      S_EPI: begin
        if (advance) begin
          if (w < W_EPI_LAST) begin
            w_nxt = w + WW'(1);
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags decoded from the upcoming state so they register alongside it
  always_comb begin
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    in_body_nxt = 1'b0;
    case (state_nxt)
      S_PRO:   busy_nxt = 1'b1;
      S_BODY: begin
        busy_nxt    = 1'b1;
        in_body_nxt = 1'b1;
      end
      S_EPI:   busy_nxt = 1'b1;
      S_DONE:  done_nxt = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  assign fetch_addr = {w, 2'b00};

`ifdef LOOP_FETCH_PERF_EN
  logic [31:0] stall_q;

  // Counts busy cycles without advance; saturates, and holds once busy drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_ok_c) begin
      stall_q <= '0;
    end else if (busy && !advance && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
